joltage_seq: RTL and testbench
==============================

// Module: joltage_seq
// PURPOSE
// Sequencer in front of one joltage core. Takes a digit stream, one digit per beat, and assembles each
// LENGTH-digit line in a line buffer. Drives the core's rst/start/data_valid protocol for every line and
// refills the buffer while the core computes. After the last line it reports both totals and the line count.
// PARAMETERS
// LENGTH      100         digits per line; must match the core's LENGTH
// TIMEOUT     LENGTH+16   max cycles in WAIT before core_done is declared lost
// CNT_W       16          width of the line counter
// PORTS
// clk              in   1          clock
// rst_n            in   1          async active-low reset
// in_valid         in   1          stream digit valid
// in_ready         out  1          stream digit accepted when in_valid&&in_ready
// in_digit         in   4          BCD digit, 0-9
// in_last          in   1          marks the final digit of the final line of a batch
// core_rst         out  1          sync active-high reset to core
// core_start       out  1          core start
// core_data_valid  out  1          core line-valid strobe
// core_line        out  4xLENGTH   line buffer; core_line[0] = first digit received
// core_done        in   1          core done level
// core_j1          in   16         core running part-1 total
// core_j2          in   64         core running part-2 total
// res_valid        out  1          batch result valid; held until res_ready
// res_ready        in   1          result consumed
// res_p1/res_p2    out  16/64      captured totals
// res_lines        out  CNT_W      lines processed in batch
// busy             out  1          FSM not in FILL with empty buffer
// err_timeout      out  1          sticky: core_done never arrived
// err_digit        out  1          sticky: accepted in_digit > 9 (digit still stored)
// BEHAVIOUR
// - Reset (rst_n low, async): FSM=CRST, fill_cnt=0, line_full=0, last_tag=0, res_*=0, res_valid=0, errs=0,
//   core_rst=1. core_start and core_data_valid are 0.
// - Fill path: accepts when in_ready = !line_full && !last_tag && FSM!=ERROR.
//   An accepted digit is written to core_line[fill_cnt] and fill_cnt increments.
//   At fill_cnt==LENGTH-1, set line_full, set last_tag=in_last, wrap fill_cnt to 0.
//   in_last on any other digit is ignored.
// - FSM (Moore outputs):
//   CRST:   core_rst=1 for 1 cycle, res_lines<=0 -> FILL.
//   FILL:   wait line_full -> START.
//   START:  core_start=1 for 1 cycle -> LOAD. The core moves IDLE/DONE->DATA.
//   LOAD:   core_data_valid=1 for 1 cycle; the core latches core_line. line_full<=0 at this edge, so refill
//           starts next cycle. Capture lt<=last_tag; res_lines++; tmo<=0 -> WAIT.
//   WAIT:   tmo++ each cycle.
//           - core_done=1 and lt=1 -> REPORT; res_p1/res_p2 <= core_j1/core_j2.
//           - core_done=1 and lt=0 -> FILL, or START directly if line_full is already 1.
//           - tmo==TIMEOUT-1 without done -> ERROR; err_timeout<=1.
//   REPORT: res_valid=1. On res_ready: res_valid<=0, last_tag<=0 -> CRST. Totals restart per batch.
//   ERROR:  core_rst=1, in_ready=0. Left only by rst_n.
// - Because last_tag blocks in_ready, no digit of the next batch enters before REPORT completes.
// - Line latency: the last digit accepted at cycle t gives core_start at t+1 (from FILL) and data_valid at t+2.
// - Widths: res_lines wraps modulo 2^CNT_W. Totals are passed through unmodified; the core's 16-bit p1 wraps.
// TESTING (LENGTH=15 in the bench; core instantiated)
// - 987654321111111 with in_last -> one result: res_p1=98, res_p2=987654321111, res_lines=1.
// - 4 lines: 987654321111111, 811111111111119, 234234234234278, 818181911112111 (last)
//   -> res_p1=357, res_p2=3121910778619, res_lines=4.
// - Stream 2nd line back-to-back during WAIT -> in_ready is low only in START/LOAD and while a full line waits.
//   The 2nd core_start occurs the cycle after done.
// - Stall res_ready 20 cycles with more input pending -> res_valid is held, in_ready=0, totals are stable.
//   After the handshake, core_rst is pulsed and the next batch totals start from 0.
// - Core model that never raises done -> err_timeout=1 at TIMEOUT cycles after LOAD; core_rst=1 and
//   in_ready=0 until reset.
// - Digit 0xC accepted -> err_digit=1 sticky. Pulling rst_n low mid-WAIT clears all outputs immediately;
//   after release, CRST is followed by FILL.

Source files
------------

// File: rtl/joltage_seq.sv
// joltage_seq: sequencer in front of one joltage core.
// Assembles LENGTH-digit lines from a one-digit-per-beat stream into a line buffer and
// drives the core's rst/start/data_valid handshake for each line. The next line refills
// while the core computes. At the end of a batch the totals and the line count are held
// on the res_* port until they are consumed.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready/in_digit/in_last  digit stream (in_last tags the final digit of a batch)
//   core_rst/core_start/core_data_valid/core_line  core control and line buffer
//   core_done/core_j1/core_j2       core status and running totals
//   res_valid/res_ready/res_p1/res_p2/res_lines  batch result handshake
//   busy, err_timeout, err_digit    status and sticky errors
module joltage_seq #(
    parameter int unsigned LENGTH  = 100,
    parameter int unsigned TIMEOUT = LENGTH + 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_digit,
    input  logic                   in_last,
    output logic                   core_rst,
    output logic                   core_start,
    output logic                   core_data_valid,
    output logic [LENGTH-1:0][3:0] core_line,
    input  logic                   core_done,
    input  logic [15:0]            core_j1,
    input  logic [63:0]            core_j2,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [15:0]            res_p1,
    output logic [63:0]            res_p2,
    output logic [CNT_W-1:0]       res_lines,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_digit
);
    localparam int unsigned FILL_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        CRST   = 3'd0,
        FILL   = 3'd1,
        START  = 3'd2,
        LOAD   = 3'd3,
        WAIT   = 3'd4,
        REPORT = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t                  state_q, state_n;
    logic [FILL_W-1:0]       fill_cnt_q, fill_cnt_n;
    logic                    line_full_q, line_full_n;
    logic                    last_tag_q, last_tag_n;
    logic                    lt_q, lt_n;
    logic [TMO_W-1:0]        tmo_q, tmo_n;
    logic                    accept_c, line_done_c;

    logic                    in_ready_n, core_rst_n, core_start_n, core_dv_n;
    logic [LENGTH-1:0][3:0]  core_line_n;
    logic                    res_valid_n, busy_n, err_timeout_n, err_digit_n;
    logic [15:0]             res_p1_n;
    logic [63:0]             res_p2_n;
    logic [CNT_W-1:0]        res_lines_n;

    assign accept_c    = in_valid && in_ready;
    assign line_done_c = accept_c && (fill_cnt_q == FILL_W'(LENGTH - 1));

    // Fill path, FSM next state, and next values of every registered output.
    always_comb begin
        state_n       = state_q;
        fill_cnt_n    = fill_cnt_q;
        line_full_n   = line_full_q;
        last_tag_n    = last_tag_q;
        lt_n          = lt_q;
        tmo_n         = tmo_q;
        core_line_n   = core_line;
        res_p1_n      = res_p1;
        res_p2_n      = res_p2;
        res_lines_n   = res_lines;
        err_timeout_n = err_timeout;
        err_digit_n   = err_digit;

        if (accept_c) begin
            core_line_n[fill_cnt_q] = in_digit;
            if (in_digit > 4'd9) begin
                err_digit_n = 1'b1;
            end
            if (line_done_c) begin
                line_full_n = 1'b1;
                last_tag_n  = in_last;
                fill_cnt_n  = '0;
            end else begin
                fill_cnt_n = fill_cnt_q + FILL_W'(1);
            end
        end

        case (state_q)
            CRST: begin
                res_lines_n = '0;
                state_n     = FILL;
            end
            // The completing digit itself triggers START so start follows it by one cycle.
            FILL: begin
                if (line_full_q || line_done_c) begin
                    state_n = START;
                end
            end
            START: begin
                state_n = LOAD;
            end
            // Core latches the buffer on this edge, so the buffer is free for refill.
            LOAD: begin
                line_full_n = 1'b0;
                lt_n        = last_tag_q;
                res_lines_n = res_lines + CNT_W'(1);
                tmo_n       = '0;
                state_n     = WAIT;
            end
            WAIT: begin
                tmo_n = tmo_q + TMO_W'(1);
                if (core_done) begin
                    if (lt_q) begin
                        res_p1_n = core_j1;
                        res_p2_n = core_j2;
                        state_n  = REPORT;
                    end else begin
                        state_n = line_full_q ? START : FILL;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_timeout_n = 1'b1;
                    state_n       = ERROR;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    last_tag_n = 1'b0;
                    state_n    = CRST;
                end
            end
            ERROR: begin
                state_n = ERROR;
            end
            default: begin
                state_n = CRST;
            end
        endcase

        // Moore outputs decoded from the next state so they register with no extra latency.
        core_rst_n   = (state_n == CRST) || (state_n == ERROR);
        core_start_n = (state_n == START);
        core_dv_n    = (state_n == LOAD);
        res_valid_n  = (state_n == REPORT);
        in_ready_n   = !line_full_n && !last_tag_n && (state_n != ERROR);
        busy_n       = !((state_n == FILL) && (fill_cnt_n == '0) && !line_full_n);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= CRST;
            fill_cnt_q      <= '0;
            line_full_q     <= 1'b0;
            last_tag_q      <= 1'b0;
            lt_q            <= 1'b0;
            tmo_q           <= '0;
            in_ready        <= 1'b1;
            core_rst        <= 1'b1;
            core_start      <= 1'b0;
            core_data_valid <= 1'b0;
            core_line       <= '0;
            res_valid       <= 1'b0;
            res_p1          <= '0;
            res_p2          <= '0;
            res_lines       <= '0;
            busy            <= 1'b1;
            err_timeout     <= 1'b0;
            err_digit       <= 1'b0;
        end else begin
            state_q         <= state_n;
            fill_cnt_q      <= fill_cnt_n;
            line_full_q     <= line_full_n;
            last_tag_q      <= last_tag_n;
            lt_q            <= lt_n;
            tmo_q           <= tmo_n;
            in_ready        <= in_ready_n;
            core_rst        <= core_rst_n;
            core_start      <= core_start_n;
            core_data_valid <= core_dv_n;
            core_line       <= core_line_n;
            res_valid       <= res_valid_n;
            res_p1          <= res_p1_n;
            res_p2          <= res_p2_n;
            res_lines       <= res_lines_n;
            busy            <= busy_n;
            err_timeout     <= err_timeout_n;
            err_digit       <= err_digit_n;
        end
    end

endmodule

// File: tb/tb_joltage_seq.sv
// tb_joltage_seq: directed bench for joltage_seq with LENGTH=15 and a behavioural core.
// Expected batch results are queued when a batch is streamed and popped when res_valid rises.
module tb_joltage_seq;
    localparam int unsigned LENGTH  = 15;
    localparam int unsigned TIMEOUT = LENGTH + 16;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic [15:0] p1;
        logic [63:0] p2;
        logic [15:0] lines;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0]             in_digit;
    logic                   in_last;
    logic                   core_rst;
    logic                   core_start;
    logic                   core_data_valid;
    logic [LENGTH-1:0][3:0] core_line;
    logic                   core_done;
    logic [15:0]            core_j1;
    logic [63:0]            core_j2;
    logic                   res_valid;
    logic                   res_ready;
    logic [15:0]            res_p1;
    logic [63:0]            res_p2;
    logic [CNT_W-1:0]       res_lines;
    logic                   busy;
    logic                   err_timeout;
    logic                   err_digit;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];

    // core model controls and state
    int          core_lat   = 3;
    logic        never_done = 1'b0;
    int          cd;
    logic [15:0] pend1;
    logic [63:0] pend2;

    // monitor counters
    int cyc       = 0;
    int stall_cnt = 0;

    always #5 clk = ~clk;

    joltage_seq #(.LENGTH(LENGTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit), .in_last(in_last),
        .core_rst(core_rst), .core_start(core_start), .core_data_valid(core_data_valid),
        .core_line(core_line), .core_done(core_done), .core_j1(core_j1), .core_j2(core_j2),
        .res_valid(res_valid), .res_ready(res_ready), .res_p1(res_p1), .res_p2(res_p2),
        .res_lines(res_lines), .busy(busy), .err_timeout(err_timeout), .err_digit(err_digit)
    );

    // Best two-digit number keeping digit order.
    function automatic logic [15:0] line_p1(input logic [LENGTH-1:0][3:0] ln);
        int best;
        int v;
        best = 0;
        for (int i = 0; i < int'(LENGTH); i++) begin
            for (int j = i + 1; j < int'(LENGTH); j++) begin
                v = 10 * int'(ln[i]) + int'(ln[j]);
                if (v > best) best = v;
            end
        end
        return 16'(best);
    endfunction

    // Best twelve-digit number keeping digit order (greedy leftmost maximum).
    function automatic logic [63:0] line_p2(input logic [LENGTH-1:0][3:0] ln);
        logic [63:0] acc;
        int pos;
        int bi;
        acc = '0;
        pos = 0;
        for (int k = 0; k < 12; k++) begin
            bi = pos;
            for (int i = pos; i <= int'(LENGTH) - 12 + k; i++) begin
                if (ln[i] > ln[bi]) bi = i;
            end
            acc = acc * 64'd10 + 64'(ln[bi]);
            pos = bi + 1;
        end
        return acc;
    endfunction

    // Behavioural core: start drops done, data_valid latches the line, done rises core_lat edges later.
    always @(posedge clk) begin
        if (core_rst) begin
            core_done <= 1'b0;
            core_j1   <= '0;
            core_j2   <= '0;
            cd        <= 0;
            pend1     <= '0;
            pend2     <= '0;
        end else begin
            if (core_start) core_done <= 1'b0;
            if (core_data_valid) begin
                pend1 <= line_p1(core_line);
                pend2 <= line_p2(core_line);
                cd    <= core_lat;
            end else if (cd != 0) begin
                cd <= cd - 1;
                if (cd == 1 && !never_done) begin
                    core_done <= 1'b1;
                    core_j1   <= core_j1 + pend1;
                    core_j2   <= core_j2 + pend2;
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && !in_ready) stall_cnt <= stall_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present one digit and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_digit(input logic [3:0] d, input logic last);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_digit = d;
        in_last  = last;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("in_ready_wait", 64'(got), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Line given as a hex literal, leftmost hex digit first; digits from index first onward.
    task automatic send_line(input logic [59:0] ln, input int first, input logic last);
        for (int i = first; i < int'(LENGTH); i++) begin
            send_digit(ln[4*(int'(LENGTH)-1-i) +: 4], last && (i == int'(LENGTH) - 1));
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check({tag, "_res_valid_wait"}, 64'(got), 64'd1);
        end else if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_p1"}, 64'(res_p1), 64'(e.p1));
            check({tag, "_p2"}, res_p2, e.p2);
            check({tag, "_lines"}, 64'(res_lines), 64'(e.lines));
        end
    endtask

    task automatic ack();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic wait_negedge_until_dv(input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (core_data_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check({tag, "_dv_wait"}, 64'(got), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int   s0;
        int   c0;
        int   c1;
        int   viol;
        bit   got;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_digit  = 4'd0;
        in_last   = 1'b0;
        res_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_lines", 64'(res_lines), 64'd0);
        check("rst_errs", 64'({err_timeout, err_digit}), 64'd0);
        check("rst_core_rst", 64'(core_rst), 64'd1);
        check("rst_core_ctl", 64'({core_start, core_data_valid}), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // single line batch and line latency
        core_lat = 3;
        sb_q.push_back('{p1: 16'd98, p2: 64'd987654321111, lines: 16'd1});
        send_line(60'h987654321111111, 0, 1'b1);
        idle();
        @(negedge clk);
        check("lat_start", 64'(core_start), 64'd1);
        @(negedge clk);
        check("lat_dv", 64'(core_data_valid), 64'd1);
        wait_valid("one_line");
        ack();

        // four line batch
        sb_q.push_back('{p1: 16'd357, p2: 64'd3121910778619, lines: 16'd4});
        send_line(60'h987654321111111, 0, 1'b0);
        send_line(60'h811111111111119, 0, 1'b0);
        send_line(60'h234234234234278, 0, 1'b0);
        send_line(60'h818181911112111, 0, 1'b1);
        idle();
        wait_valid("four_lines");
        ack();

        // back-to-back refill during WAIT; only START and LOAD stall the stream
        core_lat = 20;
        sb_q.push_back('{p1: 16'd187, p2: 64'd1798765432230, lines: 16'd2});
        s0 = stall_cnt;
        send_line(60'h987654321111111, 0, 1'b0);
        send_line(60'h811111111111119, 0, 1'b1);
        idle();
        check("b2b_stalls", 64'(stall_cnt - s0), 64'd2);
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (core_done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("b2b_done_seen", 64'(got), 64'd1);
        check("b2b_full_waits", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("b2b_start_after_done", 64'(core_start), 64'd1);
        wait_valid("b2b");
        ack();

        // result stall with next batch pending
        core_lat = 3;
        sb_q.push_back('{p1: 16'd78, p2: 64'd434234234278, lines: 16'd1});
        send_line(60'h234234234234278, 0, 1'b1);
        idle();
        wait_valid("stall");
        in_valid = 1'b1;
        in_digit = 4'd8;
        in_last  = 1'b0;
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_p1 !== 16'd78 ||
                res_p2 !== 64'd434234234278) viol++;
        end
        check("stall_hold", 64'(viol), 64'd0);
        ack();
        @(negedge clk);
        check("stall_core_rst_pulse", 64'(core_rst), 64'd1);
        check("stall_ready_after_ack", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        sb_q.push_back('{p1: 16'd92, p2: 64'd888911112111, lines: 16'd1});
        send_line(60'h818181911112111, 1, 1'b1);
        idle();
        wait_valid("after_stall");
        ack();

        // bad digit, then async reset in the middle of WAIT
        core_lat = 20;
        send_line(60'h98765432C111111, 0, 1'b1);
        idle();
        @(negedge clk);
        check("digit_err_set", 64'(err_digit), 64'd1);
        wait_negedge_until_dv("digit");
        repeat (3) @(negedge clk);
        check("digit_err_sticky", 64'(err_digit), 64'd1);
        check("wait_res_lines", 64'(res_lines), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_res_p1", 64'(res_p1), 64'd0);
        check("arst_res_lines", 64'(res_lines), 64'd0);
        check("arst_errs", 64'({err_timeout, err_digit, res_valid}), 64'd0);
        check("arst_core_ctl", 64'({core_rst, core_start, core_data_valid}), 64'b100);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_fill_core_rst", 64'(core_rst), 64'd0);
        check("arst_fill_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // core never finishes
        never_done = 1'b1;
        send_line(60'h987654321111111, 0, 1'b0);
        idle();
        wait_negedge_until_dv("tmo");
        c0 = cyc;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        c1 = cyc;
        check("tmo_seen", 64'(got), 64'd1);
        // dv is sampled in the LOAD cycle; the error lands TIMEOUT edges after the LOAD edge
        check("tmo_delay", 64'(c1 - c0), 64'(TIMEOUT + 1));
        in_valid = 1'b1;
        in_digit = 4'd5;
        viol = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (core_rst !== 1'b1 || in_ready !== 1'b0 || err_timeout !== 1'b1) viol++;
        end
        check("tmo_error_hold", 64'(viol), 64'd0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
